// File: rtl/mac_pkg.sv
// Shared constants and operand-extension helper for the MAC row and its tiles.
package mac_pkg;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_LOAD  = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;
  localparam logic [1:0] INST_DRAIN = 2'b11;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Operands arrive zero-padded to 32 bits; in signed mode they are sign-extended
  // from bit w-1 before the multiply so the product is correct at any psum width.
  function automatic logic signed [63:0] ext_prod(input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input int          w,
                                                  input bit          sgn);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    ax = $signed({32'd0, a});
    bx = $signed({32'd0, b});
    if (sgn) begin
      ax = (ax <<< (64 - w)) >>> (64 - w);
      bx = (bx <<< (64 - w)) >>> (64 - w);
    end
    return ax * bx;
  endfunction

endpackage

// File: rtl/mac_tile_acc.sv
// One MAC tile: stationary weight, forwarded activation/instruction, pass-through
// psum or local accumulator released by drain.
module mac_tile_acc
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      a_in,
  input  logic [1:0]         inst_in,
  input  logic [psum_bw-1:0] in_n,
  input  logic               mode,
  input  logic               clr,
  output logic [bw-1:0]      a_q,
  output logic [1:0]         inst_q,
  output logic [psum_bw-1:0] c_q,
  output logic               vld_p0
);

  logic [bw-1:0]             b_q;
  logic                      load_ready;
  logic signed [psum_bw-1:0] acc_q;
  logic signed [psum_bw-1:0] prod;

  assign prod = $signed(psum_bw'(ext_prod(32'(a_in), 32'(b_q), bw, SIGNED != 0)));

  // p0: single register stage; product is formed from the incoming activation
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      inst_q     <= INST_IDLE;
      vld_p0     <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      vld_p0 <= 1'b0;
      inst_q <= INST_IDLE;
      if (clr) begin
        load_ready <= 1'b1;
        acc_q      <= '0;
      end
      case (inst_in)
        INST_LOAD: begin
          if (load_ready) begin
            b_q        <= a_in;
            load_ready <= 1'b0;
          end else begin
            a_q    <= a_in;
            inst_q <= INST_LOAD;
          end
        end
        INST_EXEC: begin
          a_q    <= a_in;
          inst_q <= INST_EXEC;
          if (mode == MODE_PASS) begin
            c_q    <= in_n + prod;
            vld_p0 <= 1'b1;
          end else begin
            acc_q <= acc_q + prod;
          end
        end
        INST_DRAIN: begin
          // A drain in pass-through mode has nothing to release and dies here.
          if (mode == MODE_ACC) begin
            c_q    <= acc_q;
            vld_p0 <= 1'b1;
            acc_q  <= '0;
            inst_q <= INST_DRAIN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mac_row_acc.sv
// MAC row: col tiles chained east, shared mode register, busy flag and
// idle-only qualification of mode changes and kernel re-arm.
module mac_row_acc
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int SIGNED  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w,
  input  logic [1:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  input  logic                   acc_mode,
  input  logic                   kernel_clr,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   busy
);

  logic [bw-1:0] a_chain    [col+1];
  logic [1:0]    inst_chain [col+1];
  logic [col-1:0] tile_busy;
  logic           mode_q;
  logic           clr_ok;

  assign a_chain[0]    = in_w;
  assign inst_chain[0] = inst_w;

  assign busy   = (inst_w != INST_IDLE) || (|tile_busy);
  assign clr_ok = kernel_clr && !busy;

  // Mode only moves when nothing is in flight, so every tile sees one mode per instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_PASS;
    end else if (!busy) begin
      mode_q <= acc_mode;
    end
  end

  for (genvar j = 0; j < col; j++) begin : g_tile
    mac_tile_acc #(
      .bw      (bw),
      .psum_bw (psum_bw),
      .SIGNED  (SIGNED)
    ) u_tile (
      .clk     (clk),
      .reset   (reset),
      .a_in    (a_chain[j]),
      .inst_in (inst_chain[j]),
      .in_n    (in_n[psum_bw*j +: psum_bw]),
      .mode    (mode_q),
      .clr     (clr_ok),
      .a_q     (a_chain[j+1]),
      .inst_q  (inst_chain[j+1]),
      .c_q     (out_s[psum_bw*j +: psum_bw]),
      .vld_p0  (valid[j])
    );

    assign tile_busy[j] = (inst_chain[j+1] != INST_IDLE);
  end

endmodule
